// File: rtl/rfile_pkg.sv
// Shared register-file definitions: word/index widths and the writeback
// request record used by the register file and its writeback arbiter.
package rfile_pkg;

  localparam int RF_DW = 32;
  localparam int RF_AW = 5;

  // idx is the destination register ("reg" is a reserved word)
  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] idx;
    logic [RF_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. ptr_q=0 favours req[0], 1 favours req[1].
// The pointer flips to the other requester after every grant, contended or not,
// and holds when nothing is granted (including while en is low).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  // Grant selection and pointer advance
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    if (|gnt) ptr_d = gnt[0];
  end

  // Pointer register, reset favours requester 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rfile_wb_arb.sv
// Writeback arbiter for the register file write port. Ports A (ALU) and B
// (load return) share the port round-robin; each accepted write sits one
// cycle in a stage that drives the write port and the decode hazard check.
// Optional build macro RFILE_WB_R0_DISCARD_EN: writes to register 0 still
// handshake and advance the round-robin pointer but never enter the stage.
module rfile_wb_arb
  import rfile_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  input  logic          wb_stall,
  output logic          write_en,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic          pend_valid,
  output logic [AW-1:0] pend_reg
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } stage_t;

  logic [1:0]    gnt;
  logic          arb_en;
  logic          acc;
  logic          load;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;
  stage_t        stage_q, stage_d;

  // rst is folded in so readys stay low for the whole reset window
  assign arb_en = ~wb_stall & rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign acc     = |gnt;

  // Mux the granted request and decide whether it enters the stage
  always_comb begin
    sel_reg  = gnt[1] ? b_reg  : a_reg;
    sel_data = gnt[1] ? b_data : a_data;
`ifdef RFILE_WB_R0_DISCARD_EN
    load     = acc & (sel_reg != '0);
`else
    load     = acc;
`endif
  end

  // Stage next-state: stall freezes it, otherwise it drains every cycle
  // and reloads from an acceptance in the same cycle
  always_comb begin
    stage_d = stage_q;
    if (!wb_stall) begin
      stage_d.valid = 1'b0;
      if (load) begin
        stage_d.valid = 1'b1;
        stage_d.idx   = sel_reg;
        stage_d.data  = sel_data;
      end
    end
  end

  // Stage register; reset drops any staged write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stage_q <= '0;
    else      stage_q <= stage_d;
  end

  assign write_en   = stage_q.valid & ~wb_stall;
  assign write_reg  = stage_q.idx;
  assign write_data = stage_q.data;
  assign pend_valid = stage_q.valid;
  assign pend_reg   = stage_q.idx;

endmodule

// File: tb/tb_rfile_wb_arb.sv
// Self-checking bench for rfile_wb_arb: directed scenarios followed by a
// randomized run, all against a cycle-level reference model of the rules.
module tb_rfile_wb_arb;
  import rfile_pkg::*;

  localparam int DW = RF_DW;
  localparam int AW = RF_AW;
`ifdef RFILE_WB_R0_DISCARD_EN
  localparam bit R0_DISC = 1'b1;
`else
  localparam bit R0_DISC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0, wb_stall = 1'b0;
  logic [AW-1:0] a_reg = '0, b_reg = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, write_en, pend_valid;
  logic [AW-1:0] write_reg, pend_reg;
  logic [DW-1:0] write_data;

  always #5 clk = ~clk;

  rfile_wb_arb #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_reg      (a_reg),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_reg      (b_reg),
    .b_data     (b_data),
    .wb_stall   (wb_stall),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pend_valid (pend_valid),
    .pend_reg   (pend_reg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: staged write and which port is favoured (0=A, 1=B)
  logic          m_sv = 1'b0, m_fav = 1'b0;
  logic [AW-1:0] m_sr = '0;
  logic [DW-1:0] m_sd = '0;

  // observed values from the last sampled cycle
  logic          o_ar, o_br, o_we, o_pv;
  logic [AW-1:0] o_wr, o_pr;
  logic [DW-1:0] o_wd;

  // register file as seen through the write port
  logic [DW-1:0] rf_obs [32];
  always @(posedge clk) if (write_en) rf_obs[write_reg] <= write_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample/check at negedge, advance model at posedge.
  // Called just after a posedge with inputs already driven.
  task automatic cyc();
    logic en, ga, gb, nsv, nfav;
    logic [AW-1:0] nsr, rq;
    logic [DW-1:0] nsd;
    @(negedge clk);
    en = rst & ~wb_stall;
    ga = en & a_valid & (~b_valid | ~m_fav);
    gb = en & b_valid & (~a_valid |  m_fav);
    o_ar = a_ready; o_br = b_ready; o_we = write_en; o_pv = pend_valid;
    o_wr = write_reg; o_wd = write_data; o_pr = pend_reg;
    chk("a_ready",    64'(a_ready),    64'(ga));
    chk("b_ready",    64'(b_ready),    64'(gb));
    chk("write_en",   64'(write_en),   64'(m_sv & ~wb_stall));
    chk("write_reg",  64'(write_reg),  64'(m_sr));
    chk("write_data", 64'(write_data), 64'(m_sd));
    chk("pend_valid", 64'(pend_valid), 64'(m_sv));
    chk("pend_reg",   64'(pend_reg),   64'(m_sr));
    nsv = m_sv; nsr = m_sr; nsd = m_sd; nfav = m_fav;
    if (!rst) begin
      nsv = 1'b0; nsr = '0; nsd = '0; nfav = 1'b0;
    end else if (!wb_stall) begin
      nsv = 1'b0;
      if (ga | gb) begin
        nfav = ga;
        rq = gb ? b_reg : a_reg;
        if (!(R0_DISC && rq == '0)) begin
          nsv = 1'b1; nsr = rq; nsd = gb ? b_data : a_data;
        end
      end
    end
    @(posedge clk);
    m_sv = nsv; m_sr = nsr; m_sd = nsd; m_fav = nfav;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    for (int i = 0; i < 32; i++) rf_obs[i] = '0;
    @(posedge clk); #1;

    // reset held with both ports requesting
    a_valid = 1; a_reg = 5'd1; a_data = 32'h11;
    b_valid = 1; b_reg = 5'd2; b_data = 32'h22;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst_a_ready", 64'(o_ar), 64'(0));
      chk("rst_b_ready", 64'(o_br), 64'(0));
      chk("rst_pend",    64'(o_pv), 64'(0));
    end
    rst = 1;
    cyc();
    chk("rst_first_a", 64'(o_ar), 64'(1));
    chk("rst_first_b", 64'(o_br), 64'(0));

    // single write, then a B-only write
    a_valid = 1; a_reg = 5'd5; a_data = 32'hDEADBEEF; b_valid = 0;
    cyc();
    chk("single_ready", 64'(o_ar), 64'(1));
    a_valid = 0; b_valid = 1; b_reg = 5'd9; b_data = 32'h99;
    cyc();
    chk("single_we",   64'(o_we), 64'(1));
    chk("single_wr",   64'(o_wr), 64'(5));
    chk("single_wd",   64'(o_wd), 64'(32'hDEADBEEF));
    chk("single_pr",   64'(o_pr), 64'(5));
    chk("b_only_rdy",  64'(o_br), 64'(1));

    // continuous contention alternates A, B, A, B
    a_valid = 1; a_reg = 5'd1; a_data = 32'h11;
    b_valid = 1; b_reg = 5'd2; b_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("cont_a", 64'(o_ar), 64'(k % 2 == 0));
      chk("cont_b", 64'(o_br), 64'(k % 2 == 1));
      if (k > 0) chk("cont_wr", 64'(o_wr), 64'((k % 2 == 1) ? 1 : 2));
    end
    a_valid = 0; b_valid = 0;
    cyc();
    chk("cont_wr_last", 64'(o_wr), 64'(2));

    // same-register collision, A favoured: B's value lands last
    a_valid = 1; a_reg = 5'd7; a_data = 32'hAAAA;
    b_valid = 1; b_reg = 5'd7; b_data = 32'hBBBB;
    cyc();
    chk("coll_a_first", 64'(o_ar), 64'(1));
    a_valid = 0;
    pulses = 0;
    cyc();
    chk("coll_b_second", 64'(o_br), 64'(1));
    pulses += int'(o_we);
    b_valid = 0;
    cyc(); pulses += int'(o_we);
    cyc(); pulses += int'(o_we);
    chk("coll_pulses", 64'(pulses), 64'(2));
    chk("coll_rf7", 64'(rf_obs[7]), 64'(32'hBBBB));

    // stall freezes a staged write to reg 3
    a_valid = 1; a_reg = 5'd3; a_data = 32'h33;
    cyc();
    a_valid = 0; b_valid = 1; b_reg = 5'd8; b_data = 32'h88; wb_stall = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_we",  64'(o_we), 64'(0));
      chk("stall_pv",  64'(o_pv), 64'(1));
      chk("stall_pr",  64'(o_pr), 64'(3));
      chk("stall_rdy", 64'({o_ar, o_br}), 64'(0));
    end
    wb_stall = 0;
    cyc();
    chk("unstall_we", 64'(o_we), 64'(1));
    chk("unstall_wr", 64'(o_wr), 64'(3));
    chk("unstall_br", 64'(o_br), 64'(1));

    // write to register 0 from B, then contention must favour A
    a_valid = 0; b_valid = 1; b_reg = 5'd0; b_data = 32'h1234;
    cyc();
    chk("r0_b_ready", 64'(o_br), 64'(1));
    a_valid = 1; a_reg = 5'd4; a_data = 32'h44;
    b_valid = 1; b_reg = 5'd6; b_data = 32'h66;
    cyc();
    chk("r0_next_a", 64'(o_ar), 64'(1));
    chk("r0_we",     64'(o_we), 64'(R0_DISC ? 0 : 1));
    if (!R0_DISC) chk("r0_wr", 64'(o_wr), 64'(0));
    a_valid = 0; b_valid = 0;
    cyc();

    // asynchronous reset with a write staged
    a_valid = 1; a_reg = 5'd10; a_data = 32'hAB;
    cyc();
    rst = 0;
    #1;
    chk("midrst_pv", 64'(pend_valid), 64'(0));
    chk("midrst_we", 64'(write_en),   64'(0));
    chk("midrst_ar", 64'(a_ready),    64'(0));
    m_sv = 0; m_sr = '0; m_sd = '0; m_fav = 0;
    cyc();
    rst = 1;

    // randomized traffic; requesters hold each request until readied
    a_valid = 0; b_valid = 0;
    for (int k = 0; k < 1500; k++) begin
      if (o_ar || !a_valid) begin
        a_valid = ($urandom_range(2, 0) != 0);
        a_reg   = ($urandom_range(3, 0) == 0) ? 5'd0 : AW'($urandom);
        a_data  = $urandom;
      end
      if (o_br || !b_valid) begin
        b_valid = ($urandom_range(2, 0) != 0);
        b_reg   = ($urandom_range(3, 0) == 0) ? 5'd0 : AW'($urandom);
        b_data  = $urandom;
      end
      wb_stall = ($urandom_range(4, 0) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rfile_wb_arb.md
# rfile_wb_arb

Writeback arbiter for the 32 x 32 register file's single write port. Two writeback sources share that port: port A (ALU result) and port B (load return). Each source uses a valid/ready handshake, and grants alternate round-robin. Each accepted write is held for one cycle in an output stage that drives the register file's write port and exposes a pending-write indication for decode hazard checks.

## Interface
Parameters:
- DW, 32, data width; must match the register file word.
- AW, 5, register index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- a_valid  in  1  port A has a write request.
- a_ready  out  1  port A request accepted this cycle.
- a_reg  in  AW  port A destination register.
- a_data  in  DW  port A write data.
- b_valid, b_ready, b_reg, b_data: same as port A, for port B.
- wb_stall  in  1  freeze the writeback stage.
- write_en  out  1  to register file write_en.
- write_reg  out  AW  to register file write_reg.
- write_data  out  DW  to register file write_data.
- pend_valid  out  1  a write is staged and not yet committed.
- pend_reg  out  AW  register index of the staged write.

## Operation
- State:
  - stage_valid, stage_reg, stage_data.
  - rr_ptr: 0 means A is favoured, 1 means B is favoured.
- Grant, computed combinationally each cycle with wb_stall=0:
  - Only one valid: grant that port.
  - Both valid: grant the port rr_ptr favours.
  - Neither valid: no grant.
- Ready signals:
  - a_ready = grant_a & ~wb_stall & rst.
  - b_ready is the same for port B.
  - A port whose valid is low is never readied.
- rr_ptr update: on any grant, rr_ptr moves to favour the other port. This applies even without contention. With no grant, rr_ptr holds.
- On acceptance, the stage loads {1, reg, data} from the granted port.
- With no acceptance and wb_stall=0, stage_valid clears. With wb_stall=1, the stage holds all contents.
- Register-file outputs:
  - write_en = stage_valid & ~wb_stall.
  - write_reg = stage_reg.
  - write_data = stage_data.
- Pending outputs: pend_valid = stage_valid; pend_reg = stage_reg.
- Both ports targeting the same register in one cycle: the writes commit in grant order, and the later grant wins the final value.
- Requesters must hold valid, reg and data stable until ready. The block does not check this.

## Timing
- Acceptance in cycle N produces write_en=1 in cycle N+1. The register file captures the write at the end of N+1, and reads see it from N+2.
- Throughput is one write per cycle. Under continuous contention, grants alternate A, B, A, B.
- wb_stall=1:
  - a_ready=b_ready=0 and write_en=0.
  - The stage and rr_ptr hold.
  - The staged write issues in the first cycle after wb_stall falls.
- The stage is always free whenever wb_stall=0, so a new acceptance never waits on the stage draining.
- Reset asserted (rst=0), asynchronously at any time:
  - stage_valid=0, stage_reg=0, stage_data=0, rr_ptr=0 (A favoured).
  - Therefore write_en=0, write_reg=0, write_data=0, pend_valid=0, pend_reg=0.
  - a_ready=b_ready=0 throughout reset.
  - A staged write is dropped when reset arrives mid-operation.
- First edge after reset release: normal arbitration.

## Configuration
- RFILE_WB_R0_DISCARD_EN defined: a write to register 0 completes its handshake and advances rr_ptr, but does not load the stage. stage_valid stays 0 for that write, so write_en and pend_valid are never raised for register 0.
- Undefined: register 0 is written like any other register.

## Structure
- Shared package rfile_pkg: RF_DW=32, RF_AW=5, and typedef wb_req_t {valid, reg, data}. The register file and this block both use it.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter with inputs req[1:0], en and clk/rst, and output gnt[1:0]. It contains rr_ptr.
- The stage and the macro logic stay in the top module.

## Test plan
- Reset check: hold rst=0 while a_valid=1 and b_valid=1.
  - During reset: all outputs 0, including a_ready=0 and b_ready=0.
  - After release: A is granted first.
- Single write: A writes reg 5, data 0xDEADBEEF, in cycle N.
  - a_ready=1 in N.
  - In N+1: write_en=1, write_reg=5, write_data=0xDEADBEEF, pend_reg=5.
- Contention: A and B both valid for 4 cycles, with A reg 1/data 0x11 and B reg 2/data 0x22.
  - Grants are A, B, A, B.
  - write_reg sequence one cycle later is 1, 2, 1, 2.
- Same-register collision: A writes reg 7 = 0xAAAA and B writes reg 7 = 0xBBBB in the same cycle, rr_ptr=A.
  - write_en pulses twice.
  - Register 7 ends at 0xBBBB.
- Stall: stage loaded with reg 3, then wb_stall=1 for 3 cycles.
  - During the stall: write_en=0, pend_valid=1, readys 0.
  - write_en=1 with reg 3 in the cycle after the stall falls.
- Macro: with RFILE_WB_R0_DISCARD_EN, B writes reg 0 = 0x1234: b_ready=1, write_en stays 0, and the next grant goes to A. Without the macro: write_en=1 with write_reg=0.
